// File: rtl/divide_by_4_pkg.sv
// Shared defaults and parameter-legality helpers for the divide_by_4 clock divider.
package divide_by_4_pkg;

  localparam int DEF_DIV_RATIO   = 4;
  localparam int DEF_HIGH_CYCLES = 2;
  localparam int DEF_CNT_W       = 3;

  function automatic bit div_ratio_ok(input int div_ratio, input int cnt_w);
    return (div_ratio >= 2) && (div_ratio <= (1 << cnt_w));
  endfunction

  function automatic bit high_cycles_ok(input int high_cycles, input int div_ratio);
    return (high_cycles >= 1) && (high_cycles <= div_ratio - 1);
  endfunction

endpackage

// File: rtl/divide_by_4_mod_counter.sv
// Free-running modulo-DIV_RATIO counter; exposes the registered value and its next value.
module divide_by_4_mod_counter
  import divide_by_4_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DIV_RATIO = DEF_DIV_RATIO
) (
  input  logic             clockin,
  input  logic             reset,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_RATIO - 1);

  // >= rather than == so an out-of-range code falls back to 0 on the next edge
  always_comb begin
    count_next = count + CNT_W'(1);
    if (count >= LAST) count_next = '0;
  end

  always_ff @(posedge clockin) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end

endmodule

// File: rtl/divide_by_4.sv
// Registered clock divider: clockout is high for the last HIGH_CYCLES counts of each period.
module divide_by_4
  import divide_by_4_pkg::*;
#(
  parameter int DIV_RATIO   = DEF_DIV_RATIO,
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clockin,
  input  logic             reset,
  output logic [CNT_W-1:0] count,
  output logic             clockout
);

  if (!div_ratio_ok(DIV_RATIO, CNT_W)) begin : g_bad_div_ratio
    $error("divide_by_4: DIV_RATIO must be in [2, 2**CNT_W]");
  end
  if (!high_cycles_ok(HIGH_CYCLES, DIV_RATIO)) begin : g_bad_high_cycles
    $error("divide_by_4: HIGH_CYCLES must be in [1, DIV_RATIO-1]");
  end

  localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(DIV_RATIO - HIGH_CYCLES);

  logic [CNT_W-1:0] count_next;

  divide_by_4_mod_counter #(
    .CNT_W     (CNT_W),
    .DIV_RATIO (DIV_RATIO)
  ) u_cnt (
    .clockin    (clockin),
    .reset      (reset),
    .count      (count),
    .count_next (count_next)
  );

  // Decode from count_next so clockout lines up with count in the same edge
  always_ff @(posedge clockin) begin
    if (reset) clockout <= 1'b0;
    else       clockout <= (count_next >= RISE_AT);
  end

endmodule

// File: tb/tb_divide_by_4.sv
// Bench for divide_by_4: default divide-by-4 and a divide-by-5 variant against a phase scoreboard.
module tb_divide_by_4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cnt4, cnt5;
  logic       out4, out5;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divide_by_4 u_dut4 (
    .clockin  (clk),
    .reset    (reset),
    .count    (cnt4),
    .clockout (out4)
  );

  divide_by_4 #(.DIV_RATIO(5), .HIGH_CYCLES(2), .CNT_W(3)) u_dut5 (
    .clockin  (clk),
    .reset    (reset),
    .count    (cnt5),
    .clockout (out5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int   c4;
    bit   o4;
    int   c5;
    bit   o5;
  } exp_t;

  exp_t sb[$];

  // Phase model: cycles elapsed since the last reset edge, taken modulo each period
  int  ph4 = 0, ph5 = 0;
  bit  seen_reset = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      ph4 = 0; ph5 = 0; seen_reset = 1'b1;
    end else begin
      ph4 = (ph4 + 1) % 4;
      ph5 = (ph5 + 1) % 5;
    end
    if (seen_reset) begin
      e.c4 = ph4; e.o4 = (ph4 >= 2);
      e.c5 = ph5; e.o5 = (ph5 >= 3);
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_cnt4", 32'(cnt4), 32'(e.c4));
      check("sb_out4", 32'(out4), 32'(e.o4));
      check("sb_cnt5", 32'(cnt5), 32'(e.c5));
      check("sb_out5", 32'(out5), 32'(e.o5));
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_cnt [6];
    int exp_out [6];
    int hi, prev, guard, gap;
    bit bad;

    exp_cnt = '{1, 2, 3, 0, 1, 2};
    exp_out = '{0, 1, 1, 0, 0, 1};

    // Reset hold: samples at 10 and 20 ns
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_cnt", 32'(cnt4), 32'd0);
      check("rst_out", 32'(out4), 32'd0);
    end
    reset = 1'b0;

    // Release: edges at 25..75 ns sampled at 30..80 ns
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rel_cnt%0d", i), 32'(cnt4), 32'(exp_cnt[i]));
      check($sformatf("rel_out%0d", i), 32'(out4), 32'(exp_out[i]));
    end
    repeat (2) @(negedge clk);
    check("fall_95", 32'(out4), 32'd0);
    repeat (2) @(negedge clk);
    check("rise_115", 32'(out4), 32'd1);

    // Duty over 10 output periods
    bad = 1'b0;
    for (int p = 0; p < 10; p++) begin
      hi = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        hi += int'(out4);
        if (cnt4 > 3'd3 || cnt4[2] !== 1'b0 || out4 !== cnt4[1]) bad = 1'b1;
      end
      check($sformatf("duty_p%0d", p), 32'(hi), 32'd2);
    end
    check("cnt_range", 32'(bad), 32'd0);

    // Mid-operation reset while count=2
    guard = 0;
    while (cnt4 !== 3'd2 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("find_cnt2", 32'(cnt4), 32'd2);
    check("find_out1", 32'(out4), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_cnt", 32'(cnt4), 32'd0);
    check("mid_rst_out", 32'(out4), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("resume_cnt%0d", i), 32'(cnt4), 32'(i + 1));
      check($sformatf("resume_out%0d", i), 32'(out4), 32'(i >= 1));
    end

    // Reset pulse that misses every rising edge
    for (int i = 0; i < 3; i++) begin
      prev = int'(cnt4);
      #1 reset = 1'b1;
      #3 reset = 1'b0;
      @(negedge clk);
      check($sformatf("glitch_cnt%0d", i), 32'(cnt4), 32'((prev + 1) % 4));
    end

    // Divide-by-5 variant: period between clockout rises
    guard = 0;
    while (!(out5 === 1'b0) && guard < 10) begin @(negedge clk); guard++; end
    while (!(out5 === 1'b1) && guard < 20) begin @(negedge clk); guard++; end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!(out5 === 1'b1 && cnt5 === 3'd3) && gap < 20);
    check("div5_period", 32'(gap), 32'd5);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cnt5 > 3'd4 || out5 !== (cnt5 >= 3'd3)) bad = 1'b1;
    end
    check("div5_pattern", 32'(bad), 32'd0);

    @(negedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
